// File: rtl/dpb_pkg.sv
// dpb_pkg
//   Shared definitions for the dpb_param dual-port block RAM model.
//   - WM_* : per-port write-mode encodings (2'b11 is illegal)
//   - dpb_state_t : init/clear FSM states
//   - lane_parity : even parity per byte lane of a word
package dpb_pkg;

    localparam logic [1:0] WM_NORMAL            = 2'b00;
    localparam logic [1:0] WM_WRITE_THROUGH     = 2'b01;
    localparam logic [1:0] WM_READ_BEFORE_WRITE = 2'b10;

    // Widest word lane_parity can handle; callers zero-extend to this width.
    localparam int LP_MAX_W = 256;
    localparam int LP_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } dpb_state_t;

    // Bit i of the result is the XOR of word[i*byte_w +: byte_w]. Zero padding
    // above the real word width leaves the unused upper lanes at 0.
    function automatic logic [LP_MAX_W-1:0] lane_parity(input logic [LP_MAX_W-1:0] word,
                                                        input int byte_w);
        logic [LP_MAX_W-1:0] p;
        p = '0;
        for (int j = 0; j < LP_MAX_W; j++) begin
            p[LP_IDX_W'(j / byte_w)] = p[LP_IDX_W'(j / byte_w)] ^ word[LP_IDX_W'(j)];
        end
        return p;
    endfunction

endpackage

// File: rtl/dpb_port_out.sv
// dpb_port_out
//   Read path for one port of dpb_param: write-mode read mux, stage-1
//   register, optional output register (READ_MODE=1) and parity-error
//   alignment. Optional feature macro: DPB_PARITY_EN.
//   Ports:
//     CLKA, RESETB   clock, synchronous active-high reset
//     en             port access this cycle (RUN and CE)
//     we             port write enable for this access
//     oce            output register enable (READ_MODE=1 only)
//     old_data       array contents at the port address before the write
//     new_data       word stored at the port address by this cycle
//     old_par/new_par stored parity for old/new word (DPB_PARITY_EN)
//     dout           read data
//     perr           parity error aligned with dout (DPB_PARITY_EN)
module dpb_port_out
    import dpb_pkg::*;
#(
    parameter int         DATA_W     = 8,
`ifdef DPB_PARITY_EN
    parameter int         BYTE_W     = 8,
`endif
    parameter logic [1:0] WRITE_MODE = WM_NORMAL,
    parameter bit         READ_MODE  = 1'b0
) (
    input  logic              CLKA,
    input  logic              RESETB,
    input  logic              en,
    input  logic              we,
    input  logic              oce,
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
`ifdef DPB_PARITY_EN
    input  logic [DATA_W/BYTE_W-1:0] old_par,
    input  logic [DATA_W/BYTE_W-1:0] new_par,
    output logic              perr,
`endif
    output logic [DATA_W-1:0] dout
);

    generate
        if (WRITE_MODE == 2'b11) begin : g_bad_mode
            $error("dpb_port_out: WRITE_MODE 2'b11 is illegal");
        end
    endgenerate

    logic              load;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] stage1_data;
    logic              mode_unused;

    // Some inputs matter only for certain modes; fold them into one sink.
    assign mode_unused = ^{we, oce, new_data};

    // Choose what stage 1 captures. Normal mode leaves stage 1 untouched on
    // a write; write-through shows the stored word; read-before-write and
    // plain reads show the contents before this cycle's write.
    always_comb begin
        load     = en;
        sel_data = old_data;
        if (we) begin
            if (WRITE_MODE == WM_NORMAL) begin
                load = 1'b0;
            end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
                sel_data = new_data;
            end
        end
    end

    // Stage-1 data register; holds whenever the port is idle.
    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            stage1_data <= '0;
        end else if (load) begin
            stage1_data <= sel_data;
        end
    end

`ifdef DPB_PARITY_EN
    localparam int NB = DATA_W / BYTE_W;

    logic [NB-1:0]       sel_par;
    logic [LP_MAX_W-1:0] recomputed;
    logic                perr_next;
    logic                stage1_perr;

    // Recompute lane parity of the selected word and compare with the stored
    // bits; the flag then travels with the data through the same registers.
    always_comb begin
        sel_par    = (we && (WRITE_MODE == WM_WRITE_THROUGH)) ? new_par : old_par;
        recomputed = lane_parity(LP_MAX_W'(sel_data), BYTE_W);
        perr_next  = |(recomputed ^ LP_MAX_W'(sel_par));
    end

    // Stage-1 parity flag, loaded together with stage-1 data.
    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            stage1_perr <= 1'b0;
        end else if (load) begin
            stage1_perr <= perr_next;
        end
    end
`endif

    generate
        if (READ_MODE) begin : g_oreg
            // Second pipeline stage, advanced only by oce (ignores the port CE).
            always_ff @(posedge CLKA) begin
                if (RESETB) begin
                    dout <= '0;
                end else if (oce) begin
                    dout <= stage1_data;
                end
            end
`ifdef DPB_PARITY_EN
            always_ff @(posedge CLKA) begin
                if (RESETB) begin
                    perr <= 1'b0;
                end else if (oce) begin
                    perr <= stage1_perr;
                end
            end
`endif
        end else begin : g_direct
            assign dout = stage1_data;
`ifdef DPB_PARITY_EN
            assign perr = stage1_perr;
`endif
        end
    endgenerate

endmodule

// File: rtl/dpb_param.sv
// dpb_param
//   Parametrised true-dual-port block RAM model with byte enables, per-port
//   write/read modes, same-address collision arbitration and a post-reset
//   clear sequencer. Optional feature macro: DPB_PARITY_EN (per-lane even
//   parity storage and PERRA/PERRB outputs).
//   Ports:
//     CLKA, RESETB        shared clock, synchronous active-high reset
//     CEA/CEB, OCEA/OCEB  port enable, output-register enable
//     WREA/WREB, BEA/BEB  write enable, byte-lane write enables
//     ADA/ADB, DIA/DIB    address, write data
//     DOA/DOB             read data
//     INIT_BUSY           clear in progress, accesses ignored
//     COLLISION           one-cycle pulse after a same-address write access
//     PERRA/PERRB         parity error aligned with DOA/DOB (DPB_PARITY_EN)
module dpb_param
    import dpb_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter int         ADDR_W       = 11,
    parameter int         BYTE_W       = 8,
    parameter logic [1:0] WRITE_MODE_A = WM_NORMAL,
    parameter logic [1:0] WRITE_MODE_B = WM_NORMAL,
    parameter bit         READ_MODE_A  = 1'b0,
    parameter bit         READ_MODE_B  = 1'b0,
    parameter bit         CLEAR_ON_RST = 1'b1
) (
    input  logic                     CLKA,
    input  logic                     RESETB,
    input  logic                     CEA,
    input  logic                     CEB,
    input  logic                     OCEA,
    input  logic                     OCEB,
    input  logic                     WREA,
    input  logic                     WREB,
    input  logic [DATA_W/BYTE_W-1:0] BEA,
    input  logic [DATA_W/BYTE_W-1:0] BEB,
    input  logic [ADDR_W-1:0]        ADA,
    input  logic [ADDR_W-1:0]        ADB,
    input  logic [DATA_W-1:0]        DIA,
    input  logic [DATA_W-1:0]        DIB,
    output logic [DATA_W-1:0]        DOA,
    output logic [DATA_W-1:0]        DOB,
    output logic                     INIT_BUSY,
    output logic                     COLLISION
`ifdef DPB_PARITY_EN
    ,
    output logic                     PERRA,
    output logic                     PERRB
`endif
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
            $error("dpb_param: DATA_W must be a multiple of BYTE_W");
        end
    endgenerate

    dpb_state_t        state;
    dpb_state_t        state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              acc_a;
    logic              acc_b;
    logic              wr_a;
    logic              wr_b;
    logic              same;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [DATA_W-1:0] fin_a;
    logic [DATA_W-1:0] fin_b;

    // State register; reset parks the FSM in ST_RST.
    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // Leave reset into the clear sweep (or straight to RUN), and finish the
    // sweep once the last address has been written.
    always_comb begin
        state_next = state;
        case (state)
            ST_RST:   state_next = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (&clr_addr) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RST;
        endcase
    end

    // Clear address counter; held at 0 outside CLEAR so an aborted sweep
    // restarts from the bottom.
    always_ff @(posedge CLKA) begin
        if (RESETB || (state != ST_CLEAR)) begin
            clr_addr <= '0;
        end else begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    assign INIT_BUSY = (state == ST_CLEAR) ||
                       (CLEAR_ON_RST && (RESETB || (state == ST_RST)));

    assign run   = (state == ST_RUN);
    assign acc_a = run && CEA;
    assign acc_b = run && CEB;
    assign wr_a  = acc_a && WREA;
    assign wr_b  = acc_b && WREB;
    assign same  = (ADA == ADB);
    assign old_a = mem[ADA];
    assign old_b = mem[ADB];

    // Byte merge. On a shared address both ports compute the same final word:
    // A owns every lane it enables, B fills lanes only it enables.
    always_comb begin
        fin_a = old_a;
        fin_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wr_a && BEA[i]) begin
                fin_a[i*BYTE_W +: BYTE_W] = DIA[i*BYTE_W +: BYTE_W];
            end else if (same && wr_b && BEB[i]) begin
                fin_a[i*BYTE_W +: BYTE_W] = DIB[i*BYTE_W +: BYTE_W];
            end
            if (same && wr_a && BEA[i]) begin
                fin_b[i*BYTE_W +: BYTE_W] = DIA[i*BYTE_W +: BYTE_W];
            end else if (wr_b && BEB[i]) begin
                fin_b[i*BYTE_W +: BYTE_W] = DIB[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array update: the clear sweep owns the array; otherwise each writing
    // port stores its merged word (identical when the addresses match).
    always_ff @(posedge CLKA) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_b) mem[ADB] <= fin_b;
            if (wr_a) mem[ADA] <= fin_a;
        end
    end

    // Collision flag, registered so it shows in the cycle after the access.
    always_ff @(posedge CLKA) begin
        if (RESETB) begin
            COLLISION <= 1'b0;
        end else begin
            COLLISION <= acc_a && acc_b && same && (WREA || WREB);
        end
    end

`ifdef DPB_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] fin_par_a;
    logic [NB-1:0] fin_par_b;

    // Even parity of each lane of the words about to be stored.
    always_comb begin
        fin_par_a = '0;
        fin_par_b = '0;
        for (int i = 0; i < NB; i++) begin
            fin_par_a[i] = ^fin_a[i*BYTE_W +: BYTE_W];
            fin_par_b[i] = ^fin_b[i*BYTE_W +: BYTE_W];
        end
    end

    // Parity array follows the data array exactly, including the clear.
    always_ff @(posedge CLKA) begin
        if (state == ST_CLEAR) begin
            par[clr_addr] <= '0;
        end else begin
            if (wr_b) par[ADB] <= fin_par_b;
            if (wr_a) par[ADA] <= fin_par_a;
        end
    end
`endif

    dpb_port_out #(
        .DATA_W     (DATA_W),
`ifdef DPB_PARITY_EN
        .BYTE_W     (BYTE_W),
`endif
        .WRITE_MODE (WRITE_MODE_A),
        .READ_MODE  (READ_MODE_A)
    ) u_port_a (
        .CLKA     (CLKA),
        .RESETB   (RESETB),
        .en       (acc_a),
        .we       (WREA),
        .oce      (OCEA),
        .old_data (old_a),
        .new_data (fin_a),
`ifdef DPB_PARITY_EN
        .old_par  (par[ADA]),
        .new_par  (fin_par_a),
        .perr     (PERRA),
`endif
        .dout     (DOA)
    );

    dpb_port_out #(
        .DATA_W     (DATA_W),
`ifdef DPB_PARITY_EN
        .BYTE_W     (BYTE_W),
`endif
        .WRITE_MODE (WRITE_MODE_B),
        .READ_MODE  (READ_MODE_B)
    ) u_port_b (
        .CLKA     (CLKA),
        .RESETB   (RESETB),
        .en       (acc_b),
        .we       (WREB),
        .oce      (OCEB),
        .old_data (old_b),
        .new_data (fin_b),
`ifdef DPB_PARITY_EN
        .old_par  (par[ADB]),
        .new_par  (fin_par_b),
        .perr     (PERRB),
`endif
        .dout     (DOB)
    );

endmodule

// File: tb/tb_dpb_param.sv
// tb_dpb_param
//   Bench for dpb_param. Instance d0: 32-bit, 16 words, A read-before-write
//   with 1-cycle latency, B write-through with output register, clear on
//   reset. Instance d1: 8-bit, 16 words, normal mode, no clear.
//   Optional feature macro exercised when defined: DPB_PARITY_EN.
`timescale 1ns/1ps
module tb_dpb_param;

    logic CLKA = 1'b0;
    always #5 CLKA = ~CLKA;

    int checkCount = 0;
    int errorCount = 0;

    // d0 signals
    logic        r0, ce0a, ce0b, oce0a, oce0b, we0a, we0b;
    logic [3:0]  be0a, be0b, ad0a, ad0b;
    logic [31:0] di0a, di0b, do0a, do0b;
    logic        busy0, coll0;
    // d1 signals
    logic        r1, ce1a, ce1b, we1a, we1b;
    logic [0:0]  be1a, be1b;
    logic [3:0]  ad1a, ad1b;
    logic [7:0]  di1a, di1b, do1a, do1b;
    logic        busy1, coll1;
`ifdef DPB_PARITY_EN
    logic        perr0a, perr0b, perr1a, perr1b;
`endif

    dpb_param #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8),
                .WRITE_MODE_A(2'b10), .WRITE_MODE_B(2'b01),
                .READ_MODE_A(1'b0), .READ_MODE_B(1'b1), .CLEAR_ON_RST(1'b1)) u_d0 (
        .CLKA(CLKA), .RESETB(r0), .CEA(ce0a), .CEB(ce0b), .OCEA(oce0a), .OCEB(oce0b),
        .WREA(we0a), .WREB(we0b), .BEA(be0a), .BEB(be0b), .ADA(ad0a), .ADB(ad0b),
        .DIA(di0a), .DIB(di0b), .DOA(do0a), .DOB(do0b), .INIT_BUSY(busy0), .COLLISION(coll0)
`ifdef DPB_PARITY_EN
        , .PERRA(perr0a), .PERRB(perr0b)
`endif
    );

    dpb_param #(.DATA_W(8), .ADDR_W(4), .BYTE_W(8),
                .WRITE_MODE_A(2'b00), .WRITE_MODE_B(2'b00),
                .READ_MODE_A(1'b0), .READ_MODE_B(1'b0), .CLEAR_ON_RST(1'b0)) u_d1 (
        .CLKA(CLKA), .RESETB(r1), .CEA(ce1a), .CEB(ce1b), .OCEA(1'b0), .OCEB(1'b0),
        .WREA(we1a), .WREB(we1b), .BEA(be1a), .BEB(be1b), .ADA(ad1a), .ADB(ad1b),
        .DIA(di1a), .DIB(di1b), .DOA(do1a), .DOB(do1b), .INIT_BUSY(busy1), .COLLISION(coll1)
`ifdef DPB_PARITY_EN
        , .PERRA(perr1a), .PERRB(perr1b)
`endif
    );

    // Reference model for d0: word array plus what each port shows.
    logic [31:0] mdlMem [16];
    logic [31:0] mdlS1a, mdlS1b, mdlDob;
    logic        mdlColl;

    typedef struct {
        logic       cea, wea;
        logic [3:0] ada;
        logic [7:0] dia;
        logic       ceb, web;
        logic [3:0] adb;
        logic [7:0] dib;
        logic [7:0] expDoa, expDob;
        logic       expColl;
    } vec_t;
    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mdlMem[i] = '0;
        mdlS1a = '0; mdlS1b = '0; mdlDob = '0; mdlColl = 1'b0;
    endtask

    // One d0 cycle: drive, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic cea, input logic wea, input logic [3:0] bea,
                                 input logic [3:0] ada, input logic [31:0] dia,
                                 input logic ceb, input logic web, input logic [3:0] beb,
                                 input logic [3:0] adb, input logic [31:0] dib,
                                 input logic oceb, input string tag);
        logic [31:0] oldA, oldB;
        @(negedge CLKA);
        ce0a = cea; we0a = wea; be0a = bea; ad0a = ada; di0a = dia;
        ce0b = ceb; we0b = web; be0b = beb; ad0b = adb; di0b = dib;
        oce0b = oceb; oce0a = 1'($urandom_range(0, 1));
        oldA = mdlMem[ada];
        oldB = mdlMem[adb];
        // B first, then A on top: A wins any lane both enable.
        if (ceb && web)
            for (int l = 0; l < 4; l++) if (beb[l]) mdlMem[adb][l*8 +: 8] = dib[l*8 +: 8];
        if (cea && wea)
            for (int l = 0; l < 4; l++) if (bea[l]) mdlMem[ada][l*8 +: 8] = dia[l*8 +: 8];
        if (cea) mdlS1a = oldA;
        if (oceb) mdlDob = mdlS1b;
        if (ceb) mdlS1b = web ? mdlMem[adb] : oldB;
        mdlColl = cea && ceb && (ada == adb) && (wea || web);
        @(posedge CLKA);
        #1;
        checkOutput({tag, "_doa"}, do0a, mdlS1a);
        checkOutput({tag, "_dob"}, do0b, mdlDob);
        checkOutput({tag, "_coll"}, {31'd0, coll0}, {31'd0, mdlColl});
        checkOutput({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    endtask

    task automatic idle0(input logic oceb, input string tag);
        applyStimulus(0, 0, 4'h0, 4'd0, 32'd0, 0, 0, 4'h0, 4'd0, 32'd0, oceb, tag);
    endtask

    // Reset d0 (optionally aborting the clear part-way), then count busy cycles.
    task automatic resetAndCount(input int abortAfter, input string tag);
        int cnt;
        @(negedge CLKA);
        r0 = 1'b1; ce0a = 0; ce0b = 0; we0a = 0; we0b = 0; oce0b = 0;
        repeat (2) @(posedge CLKA);
        #1;
        checkOutput({tag, "_rst_busy"}, {31'd0, busy0}, 32'd1);
        checkOutput({tag, "_rst_doa"}, do0a, 32'd0);
        checkOutput({tag, "_rst_dob"}, do0b, 32'd0);
        checkOutput({tag, "_rst_coll"}, {31'd0, coll0}, 32'd0);
        @(negedge CLKA);
        r0 = 1'b0;
        if (abortAfter > 0) begin
            repeat (abortAfter) @(posedge CLKA);
            @(negedge CLKA);
            r0 = 1'b1;
            @(posedge CLKA);
            #1;
            checkOutput({tag, "_abort_busy"}, {31'd0, busy0}, 32'd1);
            @(negedge CLKA);
            r0 = 1'b0;
        end
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLKA);
            #1;
            if (busy0) cnt++;
            else break;
        end
        checkOutput({tag, "_busy_cycles"}, cnt, 32'd16);
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        r0 = 1; r1 = 1;
        ce0a = 0; ce0b = 0; oce0a = 0; oce0b = 0; we0a = 0; we0b = 0;
        be0a = 0; be0b = 0; ad0a = 0; ad0b = 0; di0a = 0; di0b = 0;
        ce1a = 0; ce1b = 0; we1a = 0; we1b = 0; be1a = 1; be1b = 1;
        ad1a = 0; ad1b = 0; di1a = 0; di1b = 0;
        modelReset();

        //                cea wea ada   dia    ceb web adb   dib    doa    dob    coll
        vecs[0] = '{1'b1, 1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 8'h11, 8'h11, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'd5, 8'h22, 1'b0, 1'b0, 4'd0, 8'h00, 8'h11, 8'h11, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'd7, 8'hAA, 1'b1, 1'b1, 4'd7, 8'h55, 8'h11, 8'h11, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 8'hAA, 8'h22, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b1, 4'd7, 8'h33, 8'hAA, 8'h22, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 8'h33, 8'h22, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, 8'h33, 8'h33, 1'b0};

        repeat (2) @(posedge CLKA);
        #1;
        checkOutput("d1_rst_busy", {31'd0, busy1}, 32'd0);
        checkOutput("d1_rst_doa", {24'd0, do1a}, 32'd0);
        @(negedge CLKA);
        r1 = 1'b0;

        // Clear sweep: full run, then one aborted part-way through.
        resetAndCount(0, "clr");
        resetAndCount(5, "clr_abort");

        // Every word reads back zero after the clear.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 4'h0, 4'(i), 32'd0, 1, 0, 4'h0, 4'(15 - i), 32'd0, 1, "zero");
            checkOutput("zero_doa_const", do0a, 32'd0);
        end

        // Byte-enable write, read back on both ports.
        applyStimulus(1, 1, 4'b0101, 4'd3, 32'hDEADBEEF, 0, 0, 4'h0, 4'd0, 32'd0, 0, "be_wr");
        applyStimulus(1, 0, 4'h0, 4'd3, 32'd0, 1, 0, 4'h0, 4'd3, 32'd0, 1, "be_rd");
        checkOutput("be_doa_const", do0a, 32'h00AD00EF);
        idle0(1, "be_oce");
        checkOutput("be_dob_const", do0b, 32'h00AD00EF);

        // Read-before-write on A, write-through on B.
        applyStimulus(1, 1, 4'hF, 4'd5, 32'h11, 0, 0, 4'h0, 4'd0, 32'd0, 0, "rbw1");
        applyStimulus(1, 1, 4'hF, 4'd5, 32'h22, 0, 0, 4'h0, 4'd0, 32'd0, 0, "rbw2");
        checkOutput("rbw_doa_const", do0a, 32'h11);
        applyStimulus(0, 0, 4'h0, 4'd0, 32'd0, 1, 1, 4'hF, 4'd6, 32'h33, 0, "wt_wr");
        idle0(1, "wt_oce");
        checkOutput("wt_dob_const", do0b, 32'h33);

        // Output register gated by OCEB.
        applyStimulus(1, 1, 4'hF, 4'd2, 32'h3C, 0, 0, 4'h0, 4'd0, 32'd0, 0, "oce_wr");
        applyStimulus(0, 0, 4'h0, 4'd0, 32'd0, 1, 0, 4'h0, 4'd2, 32'd0, 0, "oce_rd");
        checkOutput("oce_hold_const", do0b, 32'h33);
        idle0(1, "oce_go");
        checkOutput("oce_dob_const", do0b, 32'h3C);

        // Both ports write @7 with overlapping lanes.
        applyStimulus(1, 1, 4'b0001, 4'd7, 32'h000000AA, 1, 1, 4'b0011, 4'd7, 32'h55555555, 0, "coll_wr");
        checkOutput("coll_pulse_const", {31'd0, coll0}, 32'd1);
        applyStimulus(1, 0, 4'h0, 4'd7, 32'd0, 0, 0, 4'h0, 4'd0, 32'd0, 1, "coll_rd");
        checkOutput("coll_end_const", {31'd0, coll0}, 32'd0);
        checkOutput("coll_doa_const", do0a, 32'h000055AA);
        checkOutput("coll_dob_const", do0b, 32'h000055AA);

        // Randomised traffic; narrow address range half the time for collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] a, b;
            a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                          a, $urandom,
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                          b, $urandom, 1'($urandom_range(0, 1)), "rnd");
        end

`ifdef DPB_PARITY_EN
        applyStimulus(1, 1, 4'hF, 4'd9, 32'h12345678, 0, 0, 4'h0, 4'd0, 32'd0, 0, "par_wr");
        u_d0.mem[9][0] = ~u_d0.mem[9][0];
        mdlMem[9][0] = ~mdlMem[9][0];
        applyStimulus(1, 0, 4'h0, 4'd9, 32'd0, 0, 0, 4'h0, 4'd0, 32'd0, 0, "par_bad");
        checkOutput("par_perra_bad", {31'd0, perr0a}, 32'd1);
        checkOutput("par_doa_bad", do0a, 32'h12345679);
        applyStimulus(1, 0, 4'h0, 4'd3, 32'd0, 0, 0, 4'h0, 4'd0, 32'd0, 0, "par_good");
        checkOutput("par_perra_good", {31'd0, perr0a}, 32'd0);
`endif

        // Table-driven directed vectors on d1 (normal mode, no clear).
        for (int v = 0; v < 8; v++) begin
            @(negedge CLKA);
            ce1a = vecs[v].cea; we1a = vecs[v].wea; ad1a = vecs[v].ada; di1a = vecs[v].dia;
            ce1b = vecs[v].ceb; we1b = vecs[v].web; ad1b = vecs[v].adb; di1b = vecs[v].dib;
            @(posedge CLKA);
            #1;
            checkOutput($sformatf("vec%0d_doa", v), {24'd0, do1a}, {24'd0, vecs[v].expDoa});
            checkOutput($sformatf("vec%0d_dob", v), {24'd0, do1b}, {24'd0, vecs[v].expDob});
            checkOutput($sformatf("vec%0d_coll", v), {31'd0, coll1}, {31'd0, vecs[v].expColl});
        end
        checkOutput("d1_busy", {31'd0, busy1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
